// File: rtl/exec_ctrl_unit.sv
// Execute-stage control: resolves writeback, branch/jump redirect and load/store access.
// Optional macro EXEC_CTRL_MEM_TIMEOUT_EN bounds the wait for mem_ack_i to MEM_TIMEOUT cycles.
module exec_ctrl_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   alu_result_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              out_valid_o,
  output logic              rd_wr_en_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              jump_en_o,
  output logic [XLEN-1:0]   jump_addr_o,
  output logic              err_o
);
  // state  | meaning
  // IDLE   | ready for the next instruction
  // EXEC   | decode latched fields, emit result or launch memory access
  // MEM    | memory request outstanding, waiting for ack

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM} state_t;

  state_t            state_q;
  logic [6:0]        op_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, imm_q, pc_q, alu_q;

  logic              in_ready_q, mem_req_q, mem_we_q, out_valid_q;
  logic              rd_wr_en_q, jump_en_q, err_q;
  logic [XLEN-1:0]   mem_addr_q, mem_wdata_q, rd_data_q, jump_addr_q;
  logic [NB-1:0]     mem_wstrb_q;

`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0]     cnt_q;
`endif

  logic [XLEN-1:0]   eff_addr, pc_imm, pc_4;
  logic [1:0]        size;
  logic              misaligned, ld_legal, st_legal, br_taken;
  logic              is_mem_d, we_d, rd_we_d, jump_en_d, err_d;
  logic [XLEN-1:0]   rd_data_d, jump_addr_d, wdata_d, load_data_d;
  logic [NB-1:0]     wstrb_d;

  assign eff_addr = rs1_q + imm_q;
  assign pc_imm   = pc_q + imm_q;
  assign pc_4     = pc_q + XLEN'(4);
  assign size     = f3_q[1:0];

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input int w,
                                             input logic sgn);
    logic [XLEN-1:0] t;
    int              sh;
    sh = XLEN - w;
    t  = v << sh;
    return sgn ? XLEN'($signed(t) >>> sh) : (t >> sh);
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = eff_addr[0];
      2'd2:    misaligned = |eff_addr[1:0];
      default: misaligned = |eff_addr[2:0];
    endcase

    ld_legal = 1'b0;
    case (f3_q)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_legal = 1'b1;
      3'b011, 3'b110:                         ld_legal = (XLEN == 64);
      default:                                ld_legal = 1'b0;
    endcase

    st_legal = 1'b0;
    case (f3_q)
      3'b000, 3'b001, 3'b010: st_legal = 1'b1;
      3'b011:                 st_legal = (XLEN == 64);
      default:                st_legal = 1'b0;
    endcase

    // lanes carry the store value replicated so any byte offset sees it
    wdata_d = '0;
    for (int b = 0; b < NB; b++) begin
      case (size)
        2'd0:    wdata_d[b*8 +: 8] = rs2_q[7:0];
        2'd1:    wdata_d[b*8 +: 8] = rs2_q[(b % 2)*8 +: 8];
        2'd2:    wdata_d[b*8 +: 8] = rs2_q[(b % 4)*8 +: 8];
        default: wdata_d[b*8 +: 8] = rs2_q[b*8 +: 8];
      endcase
    end

    wstrb_d = '0;
    case (size)
      2'd0:    wstrb_d = NB'(1);
      2'd1:    wstrb_d = NB'(3);
      2'd2:    wstrb_d = NB'(15);
      default: wstrb_d = '1;
    endcase
    wstrb_d = wstrb_d << eff_addr[OFFW-1:0];
  end

  always_comb begin
    br_taken    = 1'b0;
    is_mem_d    = 1'b0;
    we_d        = 1'b0;
    rd_we_d     = 1'b0;
    rd_data_d   = '0;
    jump_en_d   = 1'b0;
    jump_addr_d = '0;
    err_d       = 1'b0;
    case (op_q)
      OP_R, OP_I: begin
        rd_we_d   = 1'b1;
        rd_data_d = alu_q;
      end
      OP_LUI: begin
        rd_we_d   = 1'b1;
        rd_data_d = imm_q;
      end
      OP_AUIPC: begin
        rd_we_d   = 1'b1;
        rd_data_d = pc_imm;
      end
      OP_JAL: begin
        rd_we_d     = 1'b1;
        rd_data_d   = pc_4;
        jump_en_d   = 1'b1;
        jump_addr_d = pc_imm;
      end
      OP_JALR: begin
        if (f3_q != 3'b000) err_d = 1'b1;
        else begin
          rd_we_d     = 1'b1;
          rd_data_d   = pc_4;
          jump_en_d   = 1'b1;
          jump_addr_d = {eff_addr[XLEN-1:1], 1'b0};
        end
      end
      OP_BR: begin
        case (f3_q)
          3'b000:  br_taken = (rs1_q == rs2_q);
          3'b001:  br_taken = (rs1_q != rs2_q);
          3'b100:  br_taken = ($signed(rs1_q) <  $signed(rs2_q));
          3'b101:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
          3'b110:  br_taken = (rs1_q <  rs2_q);
          3'b111:  br_taken = (rs1_q >= rs2_q);
          default: err_d    = 1'b1;
        endcase
        jump_en_d   = br_taken;
        jump_addr_d = br_taken ? pc_imm : '0;
      end
      OP_LOAD: begin
        if (!ld_legal || misaligned) err_d = 1'b1;
        else is_mem_d = 1'b1;
      end
      OP_STORE: begin
        if (!st_legal || misaligned) err_d = 1'b1;
        else begin
          is_mem_d = 1'b1;
          we_d     = 1'b1;
        end
      end
      default: err_d = 1'b1;
    endcase
  end

  always_comb begin
    logic [XLEN-1:0] shifted;
    shifted     = mem_rdata_i >> {mem_addr_q[OFFW-1:0], 3'b000};
    load_data_d = '0;
    case (size)
      2'd0:    load_data_d = extend(shifted, 8,  ~f3_q[2]);
      2'd1:    load_data_d = extend(shifted, 16, ~f3_q[2]);
      2'd2:    load_data_d = extend(shifted, 32, ~f3_q[2]);
      default: load_data_d = shifted;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      f3_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      alu_q       <= '0;
      in_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      out_valid_q <= 1'b0;
      rd_wr_en_q  <= 1'b0;
      rd_data_q   <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
      err_q       <= 1'b0;
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      rd_wr_en_q  <= 1'b0;
      jump_en_q   <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            op_q       <= opcode_i;
            f3_q       <= funct3_i;
            rs1_q      <= rs1_data_i;
            rs2_q      <= rs2_data_i;
            imm_q      <= imm_i;
            pc_q       <= pc_i;
            alu_q      <= alu_result_i;
            in_ready_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= we_d;
            mem_addr_q  <= eff_addr;
            mem_wdata_q <= we_d ? wdata_d : '0;
            mem_wstrb_q <= we_d ? wstrb_d : '0;
            state_q     <= S_MEM;
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end else begin
            out_valid_q <= 1'b1;
            rd_wr_en_q  <= rd_we_d;
            rd_data_q   <= rd_data_d;
            jump_en_q   <= jump_en_d;
            jump_addr_q <= jump_addr_d;
            err_q       <= err_d;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_MEM: begin
          if (mem_ack_i) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            out_valid_q <= 1'b1;
            rd_wr_en_q  <= ~mem_we_q;
            rd_data_q   <= mem_we_q ? '0 : load_data_d;
            jump_addr_q <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
          else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            out_valid_q <= 1'b1;
            err_q       <= 1'b1;
            rd_data_q   <= '0;
            jump_addr_q <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign out_valid_o = out_valid_q;
  assign rd_wr_en_o  = rd_wr_en_q;
  assign rd_data_o   = rd_data_q;
  assign jump_en_o   = jump_en_q;
  assign jump_addr_o = jump_addr_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Self-checking bench for exec_ctrl_unit (XLEN=32): directed cases plus random instructions
// compared against an arithmetic reference model.
module tb_exec_ctrl_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, imm, pc, alu;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        out_valid, rd_wr_en, jump_en, err;
  logic [31:0] rd_data, jump_addr;

  int ncmp = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  exec_ctrl_unit #(.XLEN(32), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .funct3_i(funct3), .rs1_data_i(rs1), .rs2_data_i(rs2),
    .imm_i(imm), .pc_i(pc), .alu_result_i(alu),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_rdata_i(mem_rdata),
    .mem_ack_i(mem_ack), .out_valid_o(out_valid), .rd_wr_en_o(rd_wr_en),
    .rd_data_o(rd_data), .jump_en_o(jump_en), .jump_addr_o(jump_addr), .err_o(err)
  );

  typedef struct packed {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rd_we;
    logic [31:0] rd;
    logic        jmp;
    logic [31:0] ja;
    logic        err;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] a1, input logic [31:0] a2,
                                 input logic [31:0] im, input logic [31:0] p,
                                 input logic [31:0] al, input logic [31:0] rdat);
    exp_t        e;
    logic [31:0] a, v;
    int          n;
    bit          taken;
    e = '0;
    a = a1 + im;
    n = 1 << f3[1:0];
    case (op)
      7'b0110011, 7'b0010011: begin e.rd_we = 1; e.rd = al; end
      7'b0110111: begin e.rd_we = 1; e.rd = im; end
      7'b0010111: begin e.rd_we = 1; e.rd = p + im; end
      7'b1101111: begin e.rd_we = 1; e.rd = p + 4; e.jmp = 1; e.ja = p + im; end
      7'b1100111: begin
        if (f3 != 0) e.err = 1;
        else begin e.rd_we = 1; e.rd = p + 4; e.jmp = 1; e.ja = a - (a % 2); end
      end
      7'b1100011: begin
        taken = 0;
        case (f3)
          3'd0: taken = (a1 == a2);
          3'd1: taken = (a1 != a2);
          3'd4: taken = ($signed(a1) < $signed(a2));
          3'd5: taken = !($signed(a1) < $signed(a2));
          3'd6: taken = (a1 < a2);
          3'd7: taken = !(a1 < a2);
          default: e.err = 1;
        endcase
        e.jmp = taken;
        if (taken) e.ja = p + im;
      end
      7'b0000011: begin
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (a % n) != 0) e.err = 1;
        else begin
          e.is_mem = 1; e.addr = a; e.rd_we = 1;
          v = rdat >> (8 * (a % 4));
          if (n == 1) begin
            v = v % 256;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
          end else if (n == 2) begin
            v = v % 65536;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
          end
          e.rd = v;
        end
      end
      7'b0100011: begin
        if (f3 > 3'd2 || (a % n) != 0) e.err = 1;
        else begin
          e.is_mem = 1; e.we = 1; e.addr = a;
          e.wdata = (n == 1) ? (a2 % 256) * 32'h01010101 :
                    (n == 2) ? (a2 % 65536) * 32'h00010001 : a2;
          e.wstrb = 4'(((1 << n) - 1) << (a % 4));
        end
      end
      default: e.err = 1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] im, input logic [31:0] p,
                       input logic [31:0] al);
    @(negedge clk);
    in_valid = 1; opcode = op; funct3 = f3; rs1 = a1; rs2 = a2; imm = im; pc = p; alu = al;
    @(posedge clk); #1;
    in_valid = 0;
    check("accept_ready_low", in_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] im, input logic [31:0] p,
                           input logic [31:0] al, input logic [31:0] rdat, input int dly);
    exp_t e;
    e = model(op, f3, a1, a2, im, p, al, rdat);
    issue(op, f3, a1, a2, im, p, al);
    if (e.is_mem) begin
      check({nm, "_req"}, mem_req, 1);
      check({nm, "_we"}, mem_we, e.we);
      check({nm, "_addr"}, mem_addr, e.addr);
      check({nm, "_nov"}, out_valid, 0);
      if (e.we) begin
        check({nm, "_wdata"}, mem_wdata, e.wdata);
        check({nm, "_wstrb"}, mem_wstrb, e.wstrb);
      end
      for (int i = 1; i < dly; i++) begin
        @(posedge clk); #1;
        check({nm, "_hold"}, {mem_req, out_valid, mem_addr}, {1'b1, 1'b0, e.addr});
      end
      mem_ack = 1; mem_rdata = rdat;
      @(posedge clk); #1;
      mem_ack = 0;
      check({nm, "_ack_ov"}, {out_valid, mem_req, err, jump_en}, 4'b1000);
      check({nm, "_ack_wr"}, rd_wr_en, e.rd_we);
      if (e.rd_we) check({nm, "_ld_data"}, rd_data, e.rd);
    end else begin
      check({nm, "_ov"}, {out_valid, mem_req, in_ready}, 3'b101);
      check({nm, "_flags"}, {rd_wr_en, jump_en, err}, {e.rd_we, e.jmp, e.err});
      if (e.rd_we) check({nm, "_rd"}, rd_data, e.rd);
      if (e.jmp) check({nm, "_ja"}, jump_addr, e.ja);
    end
    @(posedge clk); #1;
    check({nm, "_idle"}, {out_valid, rd_wr_en, jump_en, err, in_ready}, 5'b00001);
  endtask

  initial begin
    logic [6:0]  ops [11];
    logic [6:0]  op;
    logic [31:0] a1, a2;
    int          got;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0000000, 7'b1111111};
    rst = 1; in_valid = 0; opcode = 0; funct3 = 0; rs1 = 0; rs2 = 0; imm = 0; pc = 0;
    alu = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", in_ready, 1);
    check("reset_outs", {out_valid, rd_wr_en, jump_en, err, mem_req, mem_we}, 6'b0);
    check("reset_buses", {mem_addr, mem_wdata, rd_data, jump_addr, mem_wstrb}, '0);
    @(negedge clk); rst = 0;

    run_instr("add", 7'b0110011, 3'd0, 32'd3, 32'd7, 32'd0, 32'd0, 32'd10, 32'd0, 1);
    run_instr("beq", 7'b1100011, 3'd0, 32'd13, 32'd13, 32'd8, 32'd10, 32'd0, 32'd0, 1);
    run_instr("bne", 7'b1100011, 3'd1, 32'd13, 32'd13, 32'd8, 32'd10, 32'd0, 32'd0, 1);
    run_instr("lb", 7'b0000011, 3'd0, 32'h100, 32'd0, 32'd3, 32'd0, 32'd0, 32'h80FFFFFF, 4);
    run_instr("sh", 7'b0100011, 3'd1, 32'h200, 32'h1234ABCD, 32'd2, 32'd0, 32'd0, 32'd0, 2);
    run_instr("lw_mis", 7'b0000011, 3'd2, 32'h100, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 1);
    run_instr("ill_op", 7'b0000000, 3'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 1);
    run_instr("jal", 7'b1101111, 3'd0, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h1000, 32'd0, 32'd0, 1);
    run_instr("jalr", 7'b1100111, 3'd0, 32'h301, 32'd0, 32'd2, 32'h40, 32'd0, 32'd0, 1);
    run_instr("jalr_bad", 7'b1100111, 3'd1, 32'h300, 32'd0, 32'd0, 32'h40, 32'd0, 32'd0, 1);
    run_instr("lui", 7'b0110111, 3'd0, 32'd0, 32'd0, 32'hABCDE000, 32'd0, 32'd0, 32'd0, 1);
    run_instr("auipc", 7'b0010111, 3'd0, 32'd0, 32'd0, 32'h1000, 32'hFFFFF800, 32'd0, 32'd0, 1);
    run_instr("blt_neg", 7'b1100011, 3'd4, 32'hFFFFFFFF, 32'd1, 32'd16, 32'd0, 32'd0, 32'd0, 1);
    run_instr("bltu_neg", 7'b1100011, 3'd6, 32'hFFFFFFFF, 32'd1, 32'd16, 32'd0, 32'd0, 32'd0, 1);
    run_instr("lhu", 7'b0000011, 3'd5, 32'h200, 32'd0, 32'd2, 32'd0, 32'd0, 32'h9ABC1234, 1);
    run_instr("sb", 7'b0100011, 3'd0, 32'h203, 32'h55, 32'd0, 32'd0, 32'd0, 32'd0, 3);

    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 10)];
      a1 = $urandom;
      a2 = ($urandom_range(0, 1) == 1) ? a1 : $urandom;
      if (op == 7'b0000011 || op == 7'b0100011) a1 = {$urandom_range(0, 255), 4'h0};
      run_instr("rand", op, 3'($urandom_range(0, 7)), a1, a2,
                (op == 7'b0000011 || op == 7'b0100011) ? 32'($urandom_range(0, 7)) : $urandom,
                $urandom, $urandom, $urandom, $urandom_range(1, 4));
    end

    // reset while a store is outstanding, then a stale ack
    issue(7'b0100011, 3'd2, 32'h400, 32'h11223344, 32'd0, 32'd0, 32'd0);
    check("rstmid_req", mem_req, 1);
    @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    check("rstmid_outs", {mem_req, mem_we, out_valid, err, in_ready}, 5'b00001);
    check("rstmid_addr", mem_addr, 0);
    @(negedge clk); rst = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    repeat (2) begin
      @(posedge clk); #1;
      check("late_ack", {out_valid, mem_req, rd_wr_en, in_ready}, 4'b0001);
    end
    mem_ack = 0;

`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
    issue(7'b0000011, 3'd2, 32'h500, 32'd0, 32'd0, 32'd0, 32'd0);
    check("to_req", mem_req, 1);
    got = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin got = i; break; end
    end
    check("to_cycles", got, 15);
    check("to_flags", {err, rd_wr_en, mem_req, in_ready}, 4'b1001);
    @(posedge clk); #1;
    check("to_idle", {out_valid, err}, 2'b00);
`else
    got = 0;
`endif

    run_instr("post", 7'b0010011, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h77, 32'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
